// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access pipeline stage: the MemSize
// encodings, the bus-handshake FSM states and the default bus timeout.
package mem_pkg;

    localparam logic [1:0] MS_BYTE = 2'b00;
    localparam logic [1:0] MS_HALF = 2'b01;
    localparam logic [1:0] MS_WORD = 2'b10;

    localparam int DEFAULT_TIMEOUT = 15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mem_load_align.sv
// Load-data alignment: picks the byte or halfword lane addressed by the low
// address bits and sign- or zero-extends it to the full register width.
module mem_load_align
    import mem_pkg::*;
#(
    parameter int size = 32
) (
    input  logic [size-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  logic [1:0]      mem_size,
    input  logic            is_unsigned,
    output logic [size-1:0] data
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Lane select followed by extension according to the access size
    always_comb begin
        byte_val = rdata[{addr_lo, 3'b000} +: 8];
        half_val = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (mem_size)
            MS_BYTE: data = {{(size-8){byte_val[7] & ~is_unsigned}}, byte_val};
            MS_HALF: data = {{(size-16){half_val[15] & ~is_unsigned}}, half_val};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: issues loads/stores on the data-RAM request/ack bus,
// stalls the front of the pipeline while the bus is busy, aligns load data and
// flags a bus error when no ack arrives within TIMEOUT request cycles.
// Optional feature: define ALIGN_CHECK_EN to reject misaligned half/word
// accesses with a one-cycle misalign_MEM pulse instead of issuing them.
module mem_access
    import mem_pkg::*;
#(
    parameter int size    = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic [size-1:0] alu_resultado_EXM,
    input  logic [size-1:0] dato_escritura_EXM,
    input  logic [4:0]      wrin_EXM,
    input  logic            RegWrite_EXM,
    input  logic            MemtoReg_EXM,
    input  logic            MemRead_EXM,
    input  logic            MemWrite_EXM,
    input  logic [1:0]      MemSize_EXM,
    input  logic            MemUnsigned_EXM,
    output logic [size-1:0] salida_ram_MEM,
    output logic [size-1:0] alu_resultado_MEM,
    output logic [4:0]      wrin_MEM,
    output logic            RegWrite_MEM,
    output logic            MemtoReg_MEM,
    output logic            stall_MEM,
    output logic            bus_error_MEM,
    output logic            misalign_MEM,
    output logic            mem_req,
    output logic            mem_we,
    output logic [size-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [size-1:0] mem_wdata,
    input  logic [size-1:0] mem_rdata,
    input  logic            mem_ack
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t          state, next_state;
    logic [CW-1:0]   cnt;
    logic            err_q;
    logic [size-1:0] load_q;
    logic [size-1:0] aligned;

    logic            memop, is_load, is_store, misaligned, go;
    logic            active, ack_take, timeout_hit, bus_err, misalign;
    logic [3:0]      store_be;
    logic [size-1:0] store_wdata;

    // A request with both read and write set is treated as a load
    assign memop    = MemRead_EXM | MemWrite_EXM;
    assign is_load  = MemRead_EXM;
    assign is_store = MemWrite_EXM & ~MemRead_EXM;

`ifdef ALIGN_CHECK_EN
    assign misaligned = ((MemSize_EXM == MS_HALF) && alu_resultado_EXM[0]) ||
                        ((MemSize_EXM != MS_BYTE) && (MemSize_EXM != MS_HALF) &&
                         (alu_resultado_EXM[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign go = memop & ~misaligned;

    mem_load_align #(.size(size)) u_align (
        .rdata       (mem_rdata),
        .addr_lo     (alu_resultado_EXM[1:0]),
        .mem_size    (MemSize_EXM),
        .is_unsigned (MemUnsigned_EXM),
        .data        (aligned)
    );

    // Store byte enables and lane-replicated write data
    always_comb begin
        store_be    = 4'b1111;
        store_wdata = dato_escritura_EXM;
        case (MemSize_EXM)
            MS_BYTE: begin
                store_be    = 4'b0001 << alu_resultado_EXM[1:0];
                store_wdata = {(size/8){dato_escritura_EXM[7:0]}};
            end
            MS_HALF: begin
                store_be    = 4'b0011 << {alu_resultado_EXM[1], 1'b0};
                store_wdata = {(size/16){dato_escritura_EXM[15:0]}};
            end
            default: ;
        endcase
    end

    // Handshake FSM: next state plus the stage outputs that depend on it
    always_comb begin
        next_state     = state;
        active         = 1'b0;
        ack_take       = 1'b0;
        timeout_hit    = 1'b0;
        bus_err        = 1'b0;
        misalign       = 1'b0;
        salida_ram_MEM = '0;
        RegWrite_MEM   = RegWrite_EXM;
        MemtoReg_MEM   = MemtoReg_EXM;
        case (state)
            ST_IDLE: begin
                if (go) begin
                    active = 1'b1;
                    if (mem_ack) begin
                        ack_take   = 1'b1;
                        next_state = ST_DONE;
                    end else begin
                        next_state = ST_REQ;
                    end
                end else if (memop) begin
                    misalign     = 1'b1;
                    RegWrite_MEM = 1'b0;
                end
            end
            ST_REQ: begin
                active = 1'b1;
                if (mem_ack) begin
                    ack_take   = 1'b1;
                    next_state = ST_DONE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    next_state  = ST_DONE;
                end
            end
            ST_DONE: begin
                next_state     = ST_IDLE;
                bus_err        = err_q;
                salida_ram_MEM = err_q ? '0 : load_q;
                RegWrite_MEM   = RegWrite_EXM & ~err_q;
            end
            default: next_state = ST_IDLE;
        endcase
        if (active) begin
            RegWrite_MEM = 1'b0;
            MemtoReg_MEM = 1'b0;
        end
    end

    assign mem_req           = active & RESET_N;
    assign stall_MEM         = active & RESET_N;
    assign mem_we            = mem_req & is_store;
    assign mem_be            = is_store ? store_be : 4'b1111;
    assign mem_wdata         = store_wdata;
    assign mem_addr          = {alu_resultado_EXM[size-1:2], 2'b00};
    assign bus_error_MEM     = bus_err & RESET_N;
    assign misalign_MEM      = misalign & RESET_N;
    assign alu_resultado_MEM = alu_resultado_EXM;
    assign wrin_MEM          = wrin_EXM;

    // State, timeout counter, error flag and captured load data
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            err_q  <= 1'b0;
            load_q <= '0;
        end else begin
            state <= next_state;
            err_q <= timeout_hit;
            if (state == ST_REQ && next_state == ST_REQ)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;
            if (ack_take)
                load_q <= is_load ? aligned : '0;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access. Inputs change 1 ns after the
// rising edge; outputs are checked on the falling edge.
// Build with ALIGN_CHECK_EN defined to exercise the misalignment trap.
module tb_mem_access;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [31:0] alu_resultado_EXM, dato_escritura_EXM, mem_rdata;
    logic [4:0]  wrin_EXM;
    logic        RegWrite_EXM, MemtoReg_EXM, MemRead_EXM, MemWrite_EXM;
    logic [1:0]  MemSize_EXM;
    logic        MemUnsigned_EXM, mem_ack;
    logic [31:0] salida_ram_MEM, alu_resultado_MEM, mem_addr, mem_wdata;
    logic [4:0]  wrin_MEM;
    logic        RegWrite_MEM, MemtoReg_MEM, stall_MEM, bus_error_MEM, misalign_MEM;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;

    int checks = 0;
    int errors = 0;

    mem_access #(.size(32), .TIMEOUT(15)) dut (
        .CLK                (CLK),
        .RESET_N            (RESET_N),
        .alu_resultado_EXM  (alu_resultado_EXM),
        .dato_escritura_EXM (dato_escritura_EXM),
        .wrin_EXM           (wrin_EXM),
        .RegWrite_EXM       (RegWrite_EXM),
        .MemtoReg_EXM       (MemtoReg_EXM),
        .MemRead_EXM        (MemRead_EXM),
        .MemWrite_EXM       (MemWrite_EXM),
        .MemSize_EXM        (MemSize_EXM),
        .MemUnsigned_EXM    (MemUnsigned_EXM),
        .salida_ram_MEM     (salida_ram_MEM),
        .alu_resultado_MEM  (alu_resultado_MEM),
        .wrin_MEM           (wrin_MEM),
        .RegWrite_MEM       (RegWrite_MEM),
        .MemtoReg_MEM       (MemtoReg_MEM),
        .stall_MEM          (stall_MEM),
        .bus_error_MEM      (bus_error_MEM),
        .misalign_MEM       (misalign_MEM),
        .mem_req            (mem_req),
        .mem_we             (mem_we),
        .mem_addr           (mem_addr),
        .mem_be             (mem_be),
        .mem_wdata          (mem_wdata),
        .mem_rdata          (mem_rdata),
        .mem_ack            (mem_ack)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic clear_inputs();
        alu_resultado_EXM  = '0;
        dato_escritura_EXM = '0;
        wrin_EXM           = '0;
        RegWrite_EXM       = 1'b0;
        MemtoReg_EXM       = 1'b0;
        MemRead_EXM        = 1'b0;
        MemWrite_EXM       = 1'b0;
        MemSize_EXM        = 2'b10;
        MemUnsigned_EXM    = 1'b0;
        mem_rdata          = '0;
        mem_ack            = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        clear_inputs();
        alu_resultado_EXM = 32'h40;
        MemRead_EXM       = 1'b1;
        RegWrite_EXM      = 1'b1;
        @(negedge CLK);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got %b exp 0", mem_req); end
        checks++; if (stall_MEM !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got %b exp 0", stall_MEM); end
        checks++; if (bus_error_MEM !== 1'b0) begin errors++; $display("[TB] FAIL reset_buserr got %b exp 0", bus_error_MEM); end
        checks++; if (misalign_MEM !== 1'b0) begin errors++; $display("[TB] FAIL reset_misalign got %b exp 0", misalign_MEM); end
        checks++; if (salida_ram_MEM !== 32'h0) begin errors++; $display("[TB] FAIL reset_salida got %h exp 0", salida_ram_MEM); end
        clear_inputs();
        RESET_N = 1'b1;
        next_cycle();
    endtask

    task automatic test_passthrough();
        alu_resultado_EXM = 32'h1234;
        RegWrite_EXM      = 1'b1;
        wrin_EXM          = 5'd7;
        @(negedge CLK);
        checks++; if (alu_resultado_MEM !== 32'h1234) begin errors++; $display("[TB] FAIL pass_alu got %h exp 1234", alu_resultado_MEM); end
        checks++; if (RegWrite_MEM !== 1'b1) begin errors++; $display("[TB] FAIL pass_regwrite got %b exp 1", RegWrite_MEM); end
        checks++; if (wrin_MEM !== 5'd7) begin errors++; $display("[TB] FAIL pass_wrin got %0d exp 7", wrin_MEM); end
        checks++; if (stall_MEM !== 1'b0) begin errors++; $display("[TB] FAIL pass_stall got %b exp 0", stall_MEM); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL pass_req got %b exp 0", mem_req); end
        checks++; if (salida_ram_MEM !== 32'h0) begin errors++; $display("[TB] FAIL pass_salida got %h exp 0", salida_ram_MEM); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_byte_load();
        int stalls;
        stalls = 0;
        alu_resultado_EXM = 32'h103;
        MemRead_EXM       = 1'b1;
        MemtoReg_EXM      = 1'b1;
        RegWrite_EXM      = 1'b1;
        MemSize_EXM       = 2'b00;
        wrin_EXM          = 5'd3;
        mem_rdata         = 32'h80FF_FF7F;
        @(negedge CLK);
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("[TB] FAIL bload_addr got %h exp 100", mem_addr); end
        checks++; if (mem_be !== 4'b1111) begin errors++; $display("[TB] FAIL bload_be got %b exp 1111", mem_be); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL bload_we got %b exp 0", mem_we); end
        checks++; if (RegWrite_MEM !== 1'b0 || MemtoReg_MEM !== 1'b0) begin errors++; $display("[TB] FAIL bload_bubble got %b%b exp 00", RegWrite_MEM, MemtoReg_MEM); end
        for (int c = 0; c < 3; c++) begin
            if (c == 2) mem_ack = 1'b1;
            @(negedge CLK);
            if (stall_MEM === 1'b1 && mem_req === 1'b1) stalls++;
            next_cycle();
        end
        mem_ack = 1'b0;
        @(negedge CLK);
        checks++; if (stalls !== 3) begin errors++; $display("[TB] FAIL bload_stall_cycles got %0d exp 3", stalls); end
        checks++; if (stall_MEM !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("[TB] FAIL bload_done_stall got %b/%b exp 0/0", stall_MEM, mem_req); end
        checks++; if (salida_ram_MEM !== 32'hFFFF_FF80) begin errors++; $display("[TB] FAIL bload_data got %h exp ffffff80", salida_ram_MEM); end
        checks++; if (RegWrite_MEM !== 1'b1 || MemtoReg_MEM !== 1'b1) begin errors++; $display("[TB] FAIL bload_done_ctrl got %b%b exp 11", RegWrite_MEM, MemtoReg_MEM); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_half_store();
        alu_resultado_EXM  = 32'h102;
        MemWrite_EXM       = 1'b1;
        MemSize_EXM        = 2'b01;
        dato_escritura_EXM = 32'h0000_BEEF;
        mem_ack            = 1'b1;
        @(negedge CLK);
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("[TB] FAIL hstore_req got %b/%b exp 1/1", mem_req, mem_we); end
        checks++; if (mem_be !== 4'b1100) begin errors++; $display("[TB] FAIL hstore_be got %b exp 1100", mem_be); end
        checks++; if (mem_wdata !== 32'hBEEF_BEEF) begin errors++; $display("[TB] FAIL hstore_wdata got %h exp beefbeef", mem_wdata); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("[TB] FAIL hstore_addr got %h exp 100", mem_addr); end
        next_cycle();
        mem_ack = 1'b0;
        @(negedge CLK);
        checks++; if (stall_MEM !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("[TB] FAIL hstore_done got %b/%b exp 0/0", stall_MEM, mem_req); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_byte_store();
        alu_resultado_EXM  = 32'h201;
        MemWrite_EXM       = 1'b1;
        MemSize_EXM        = 2'b00;
        dato_escritura_EXM = 32'h1234_5678;
        mem_ack            = 1'b1;
        @(negedge CLK);
        checks++; if (mem_be !== 4'b0010) begin errors++; $display("[TB] FAIL bstore_be got %b exp 0010", mem_be); end
        checks++; if (mem_wdata !== 32'h7878_7878) begin errors++; $display("[TB] FAIL bstore_wdata got %h exp 78787878", mem_wdata); end
        next_cycle();
        mem_ack = 1'b0;
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_half_load_unsigned();
        alu_resultado_EXM = 32'h202;
        MemRead_EXM       = 1'b1;
        RegWrite_EXM      = 1'b1;
        MemSize_EXM       = 2'b01;
        MemUnsigned_EXM   = 1'b1;
        mem_rdata         = 32'h8001_1234;
        mem_ack           = 1'b1;
        next_cycle();
        mem_ack = 1'b0;
        @(negedge CLK);
        checks++; if (salida_ram_MEM !== 32'h0000_8001) begin errors++; $display("[TB] FAIL hload_u_data got %h exp 00008001", salida_ram_MEM); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_timeout();
        int stalls;
        int early_err;
        stalls    = 0;
        early_err = 0;
        alu_resultado_EXM = 32'h40;
        MemRead_EXM       = 1'b1;
        RegWrite_EXM      = 1'b1;
        mem_rdata         = 32'h5555_5555;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (stall_MEM !== 1'b1) break;
            if (bus_error_MEM !== 1'b0) early_err++;
            stalls++;
            next_cycle();
        end
        checks++; if (stalls !== 16) begin errors++; $display("[TB] FAIL timeout_stall_cycles got %0d exp 16", stalls); end
        checks++; if (early_err !== 0) begin errors++; $display("[TB] FAIL timeout_early_err got %0d exp 0", early_err); end
        checks++; if (bus_error_MEM !== 1'b1) begin errors++; $display("[TB] FAIL timeout_buserr got %b exp 1", bus_error_MEM); end
        checks++; if (RegWrite_MEM !== 1'b0) begin errors++; $display("[TB] FAIL timeout_regwrite got %b exp 0", RegWrite_MEM); end
        checks++; if (salida_ram_MEM !== 32'h0) begin errors++; $display("[TB] FAIL timeout_salida got %h exp 0", salida_ram_MEM); end
        next_cycle();
        clear_inputs();
        @(negedge CLK);
        checks++; if (bus_error_MEM !== 1'b0 || stall_MEM !== 1'b0) begin errors++; $display("[TB] FAIL timeout_after got %b/%b exp 0/0", bus_error_MEM, stall_MEM); end
        next_cycle();
    endtask

    task automatic test_reset_mid_req();
        alu_resultado_EXM = 32'h80;
        MemRead_EXM       = 1'b1;
        RegWrite_EXM      = 1'b1;
        mem_rdata         = 32'hABCD_EF01;
        next_cycle();
        next_cycle();
        RESET_N = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || stall_MEM !== 1'b0) begin errors++; $display("[TB] FAIL midreset_outputs got %b/%b exp 0/0", mem_req, stall_MEM); end
        @(negedge CLK);
        clear_inputs();
        RESET_N = 1'b1;
        mem_ack = 1'b1;
        #1;
        checks++; if (RegWrite_MEM !== 1'b0 || stall_MEM !== 1'b0) begin errors++; $display("[TB] FAIL midreset_release got %b/%b exp 0/0", RegWrite_MEM, stall_MEM); end
        next_cycle();
        mem_ack = 1'b0;
        @(negedge CLK);
        checks++; if (RegWrite_MEM !== 1'b0 || salida_ram_MEM !== 32'h0 || stall_MEM !== 1'b0) begin errors++; $display("[TB] FAIL midreset_late_ack got rw=%b d=%h st=%b exp 0/0/0", RegWrite_MEM, salida_ram_MEM, stall_MEM); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        alu_resultado_EXM = 32'h300;
        MemRead_EXM       = 1'b1;
        RegWrite_EXM      = 1'b1;
        mem_rdata         = 32'hDEAD_BEEF;
        mem_ack           = 1'b1;
        next_cycle();
        mem_ack = 1'b0;
        @(negedge CLK);
        checks++; if (salida_ram_MEM !== 32'hDEAD_BEEF || stall_MEM !== 1'b0) begin errors++; $display("[TB] FAIL b2b_load got %h/%b exp deadbeef/0", salida_ram_MEM, stall_MEM); end
        next_cycle();
        clear_inputs();
        alu_resultado_EXM  = 32'h304;
        MemWrite_EXM       = 1'b1;
        dato_escritura_EXM = 32'hCAFE_F00D;
        mem_ack            = 1'b1;
        @(negedge CLK);
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b1111) begin errors++; $display("[TB] FAIL b2b_store_req got %b/%b/%b exp 1/1/1111", mem_req, mem_we, mem_be); end
        checks++; if (mem_wdata !== 32'hCAFE_F00D || mem_addr !== 32'h304) begin errors++; $display("[TB] FAIL b2b_store_bus got %h@%h exp cafef00d@304", mem_wdata, mem_addr); end
        next_cycle();
        mem_ack = 1'b0;
        @(negedge CLK);
        checks++; if (stall_MEM !== 1'b0 || salida_ram_MEM !== 32'h0 || RegWrite_MEM !== 1'b0) begin errors++; $display("[TB] FAIL b2b_store_done got %b/%h/%b exp 0/0/0", stall_MEM, salida_ram_MEM, RegWrite_MEM); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_misalign();
        alu_resultado_EXM = 32'h102;
        MemRead_EXM       = 1'b1;
        RegWrite_EXM      = 1'b1;
        MemSize_EXM       = 2'b10;
        mem_rdata         = 32'h1122_3344;
`ifdef ALIGN_CHECK_EN
        @(negedge CLK);
        checks++; if (misalign_MEM !== 1'b1) begin errors++; $display("[TB] FAIL misalign_pulse got %b exp 1", misalign_MEM); end
        checks++; if (mem_req !== 1'b0 || stall_MEM !== 1'b0) begin errors++; $display("[TB] FAIL misalign_noreq got %b/%b exp 0/0", mem_req, stall_MEM); end
        checks++; if (RegWrite_MEM !== 1'b0) begin errors++; $display("[TB] FAIL misalign_regwrite got %b exp 0", RegWrite_MEM); end
        next_cycle();
        clear_inputs();
        @(negedge CLK);
        checks++; if (misalign_MEM !== 1'b0) begin errors++; $display("[TB] FAIL misalign_after got %b exp 0", misalign_MEM); end
        next_cycle();
`else
        mem_ack = 1'b1;
        @(negedge CLK);
        checks++; if (misalign_MEM !== 1'b0) begin errors++; $display("[TB] FAIL misalign_tied got %b exp 0", misalign_MEM); end
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("[TB] FAIL misalign_req got %b@%h exp 1@100", mem_req, mem_addr); end
        next_cycle();
        mem_ack = 1'b0;
        @(negedge CLK);
        checks++; if (salida_ram_MEM !== 32'h1122_3344) begin errors++; $display("[TB] FAIL misalign_word_data got %h exp 11223344", salida_ram_MEM); end
        next_cycle();
        clear_inputs();
`endif
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_byte_load();
        test_half_store();
        test_byte_store();
        test_half_load_unsigned();
        test_timeout();
        test_reset_mid_req();
        test_back_to_back();
        test_misalign();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the 5-stage pipeline, between the EX/MEM register and the MEM/WB register. It issues loads and stores to the data-RAM bus with a request/acknowledge handshake, stalls the front of the pipeline while the bus is busy, and aligns and extends load data. It then hands salida_ram_MEM, alu_resultado_MEM, wrin_MEM, RegWrite_MEM and MemtoReg_MEM to the MEM/WB register.

## Interface
- size, 32, data/address width
- TIMEOUT, 15, maximum cycles in REQ before a bus error; counter width is $clog2(TIMEOUT+1)
- CLK  in  1  clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- alu_resultado_EXM  in  size  ALU result; the byte address for memory ops
- dato_escritura_EXM  in  size  store data (register rt)
- wrin_EXM  in  5  destination register
- RegWrite_EXM, MemtoReg_EXM, MemRead_EXM, MemWrite_EXM  in  1 each  control bits
- MemSize_EXM  in  2  00 byte, 01 half, 10 word, 11 treated as word
- MemUnsigned_EXM  in  1  zero-extend loads when 1
- salida_ram_MEM, alu_resultado_MEM  out  size  to MEM/WB
- wrin_MEM  out  5  to MEM/WB
- RegWrite_MEM, MemtoReg_MEM  out  1  to MEM/WB
- stall_MEM  out  1  freezes PC, IF/ID, ID/EX and EX/MEM
- bus_error_MEM  out  1  one-cycle pulse on timeout
- misalign_MEM  out  1  one-cycle pulse (only with ALIGN_CHECK_EN)
- mem_req, mem_we  out  1  bus request and write strobe
- mem_addr  out  size  word-aligned address (alu_resultado_EXM with bits [1:0] = 0)
- mem_be  out  4  byte enables
- mem_wdata  out  size  store data
- mem_rdata  in  size  read data, valid with mem_ack
- mem_ack  in  1  completion; sampled on the rising edge of CLK

## Operation
- memop = MemRead_EXM | MemWrite_EXM. If both are set, the op is a load.
- FSM states:
  - IDLE
    - memop = 0: pass-through. Outputs follow the EXM inputs; salida_ram_MEM = 0.
    - memop = 1: mem_req = 1 and stall_MEM = 1 combinationally. On ack go to DONE, otherwise to REQ.
  - REQ: hold mem_req and stall_MEM. The timeout counter increments each cycle.
    - ack: go to DONE.
    - counter reaches TIMEOUT: go to DONE with the error flag set.
  - DONE: stall_MEM = 0 and mem_req = 0. Outputs present the instruction with the captured load data. Go to IDLE.
- While stalled (IDLE-with-memop and REQ), RegWrite_MEM = 0 and MemtoReg_MEM = 0, so bubbles enter MEM/WB.
- Load data is captured into a register on the ack edge, after alignment:
  - byte: lane addr[1:0]
  - half: lane addr[1]
  - extension: sign-extended, or zero-extended when MemUnsigned_EXM = 1
- Store byte enables and data:
  - byte: mem_be = 0001 << addr[1:0], wdata = byte replicated ×4
  - half: mem_be = 0011 << 2·addr[1], wdata = half replicated ×2
  - word: mem_be = 1111, wdata unchanged
- Loads drive mem_be = 1111.
- Error in DONE:
  - bus_error_MEM = 1
  - RegWrite_MEM = 0
  - salida_ram_MEM = 0
- Reset (including mid-REQ):
  - state → IDLE, counter → 0, load register → 0
  - mem_req, stall_MEM, bus_error_MEM and misalign_MEM forced to 0 while RESET_N is low
  - an outstanding ack after reset is ignored

## Timing
- Minimum memory op is 2 cycles (ack in the IDLE cycle, then DONE). Each wait cycle adds 1.
- Non-memory ops have 0 added latency and no stall.
- EX/MEM advances only at the end of the cycle in which stall_MEM = 0, so the EXM inputs are stable for the whole op.
- The timeout fires after TIMEOUT REQ cycles. DONE follows on the next cycle.
- Back-to-back memory ops: DONE → IDLE → next request. One IDLE cycle separates them, and that IDLE cycle already asserts the new request.

## Configuration
- ALIGN_CHECK_EN defined:
  - a half with addr[0] = 1, or a word with addr[1:0] ≠ 0, issues no bus request and no stall
  - misalign_MEM pulses for that cycle and RegWrite_MEM = 0
- ALIGN_CHECK_EN undefined:
  - word ops ignore addr[1:0]
  - half ops ignore addr[0]
  - misalign_MEM is tied to 0

## Structure
- Package mem_pkg:
  - MemSize encoding constants: MS_BYTE, MS_HALF, MS_WORD
  - FSM state enum: ST_IDLE, ST_REQ, ST_DONE
  - default TIMEOUT
- Sub-module mem_load_align: combinational lane select and sign/zero extension, parameterised on size.

## Test plan
- Pass-through: ALU op, alu_resultado = 0x1234, RegWrite = 1 → outputs mirror the inputs in the same cycle; stall_MEM = 0; mem_req = 0.
- Signed byte load, addr 0x103, rdata 0x80FF_FF7F, ack after 2 wait cycles → stall for 3 cycles; the DONE cycle gives salida_ram = 0xFFFF_FF80, RegWrite = 1.
- Half store, addr 0x102, data 0x0000_BEEF, ack in the first cycle → mem_be = 1100, mem_wdata = 0xBEEF_BEEF, mem_addr = 0x100, op lasts 2 cycles.
- Timeout: load with mem_ack held low, TIMEOUT = 15 → 15 REQ cycles, then DONE with bus_error_MEM = 1, RegWrite_MEM = 0, then IDLE.
- Reset asserted mid-REQ, then released → mem_req = 0 and stall_MEM = 0 immediately; state is IDLE; a late ack causes no write.
- With ALIGN_CHECK_EN, word load at addr 0x102 → misalign_MEM = 1 for one cycle, no mem_req, RegWrite_MEM = 0.
